// File: rtl/aes_key_sched_ctrl.sv
// AES-128 key expansion sequencer: drives round/cnt for the shared-SubBytes datapath,
// captures each round key into an 11-entry store and serves it through a registered read port.
module aes_key_sched_ctrl #(
    parameter int NR       = 10,
    parameter int CNT_LAST = 7
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         abort,
    input  logic [127:0] key_in,
    output logic         busy,
    output logic         done,
    output logic         keys_valid,
    output logic [3:0]   round_o,
    output logic [2:0]   cnt_o,
    output logic [127:0] kexp_key_o,
    input  logic [127:0] round_key_i,
    input  logic         rk_rd_en,
    input  logic [3:0]   rk_rd_idx,
    output logic [127:0] rk_rd_data,
    output logic         rk_rd_valid,
    output logic         rd_err
);

    localparam logic [3:0] NR_L  = 4'(NR);
    localparam logic [2:0] CNT_L = 3'(CNT_LAST);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_EXPAND = 2'd2,
        S_FINAL  = 2'd3
    } state_e;

    state_e         state_q, state_d;
    logic [3:0]     round_q, round_d;
    logic [2:0]     cnt_q, cnt_d;
    logic [127:0]   kexp_key_q, kexp_key_d;
    logic           keys_valid_q, keys_valid_d;
    logic           done_q, done_d;
    logic [127:0]   rd_data_q, rd_data_d;
    logic           rd_valid_q, rd_valid_d;
    logic           rd_err_q, rd_err_d;

    logic           accept;
    logic           st_we;
    logic [3:0]     st_idx;
    logic [127:0]   st_wdata;

    // Key store is deliberately not reset; keys_valid gates every read.
    logic [127:0]   store_q [0:NR];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            round_q      <= '0;
            cnt_q        <= '0;
            kexp_key_q   <= '0;
            keys_valid_q <= 1'b0;
            done_q       <= 1'b0;
            rd_data_q    <= '0;
            rd_valid_q   <= 1'b0;
            rd_err_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            round_q      <= round_d;
            cnt_q        <= cnt_d;
            kexp_key_q   <= kexp_key_d;
            keys_valid_q <= keys_valid_d;
            done_q       <= done_d;
            rd_data_q    <= rd_data_d;
            rd_valid_q   <= rd_valid_d;
            rd_err_q     <= rd_err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (st_we) begin
            store_q[st_idx] <= st_wdata;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start && !abort) state_d = S_LOAD;
            S_LOAD:   state_d = abort ? S_IDLE : S_EXPAND;
            S_EXPAND: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (cnt_q == CNT_L && round_q == NR_L) begin
                    state_d = S_FINAL;
                end
            end
            S_FINAL:  state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy         = (state_q != S_IDLE);
        accept       = (state_q == S_IDLE) && start && !abort;
        round_d      = '0;
        cnt_d        = '0;
        kexp_key_d   = accept ? key_in : kexp_key_q;
        done_d       = (state_q == S_FINAL) && !abort;
        keys_valid_d = keys_valid_q;
        st_we        = 1'b0;
        st_idx       = '0;
        st_wdata     = round_key_i;

        case (state_q)
            S_LOAD: begin
                round_d = 4'd1;
            end
            S_EXPAND: begin
                if (cnt_q == CNT_L) begin
                    // Last round holds at NR; FINAL presents NR/0.
                    round_d = (round_q < NR_L) ? round_q + 4'd1 : round_q;
                end else begin
                    round_d = round_q;
                    cnt_d   = cnt_q + 3'd1;
                end
                // Key r-1 is on round_key_i in the first step of round r.
                if (cnt_q == 3'd0 && round_q >= 4'd2) begin
                    st_we  = !abort;
                    st_idx = round_q - 4'd1;
                end
            end
            S_FINAL: begin
                st_we  = !abort;
                st_idx = NR_L;
            end
            default: ;
        endcase

        if (abort && busy) begin
            round_d = '0;
            cnt_d   = '0;
        end

        if (accept) begin
            st_we    = 1'b1;
            st_idx   = '0;
            st_wdata = key_in;
        end

        if (abort || accept) begin
            keys_valid_d = 1'b0;
        end else if (state_q == S_FINAL) begin
            keys_valid_d = 1'b1;
        end

        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        rd_err_d   = 1'b0;
        if (rk_rd_en) begin
            if (keys_valid_q && !busy && rk_rd_idx <= NR_L) begin
                rd_data_d  = store_q[rk_rd_idx];
                rd_valid_d = 1'b1;
            end else begin
                rd_data_d  = '0;
                rd_err_d   = 1'b1;
            end
        end
    end

    assign done        = done_q;
    assign keys_valid  = keys_valid_q;
    assign round_o     = round_q;
    assign cnt_o       = cnt_q;
    assign kexp_key_o  = kexp_key_q;
    assign rk_rd_data  = rd_data_q;
    assign rk_rd_valid = rd_valid_q;
    assign rd_err      = rd_err_q;

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Bench for aes_key_sched_ctrl: models the external expansion datapath and checks schedule,
// timing, abort, reset and read-port behaviour against a FIPS-197 key expansion reference.
module tb_aes_key_sched_ctrl;
    localparam int NR = 10;
    localparam logic [127:0] FIPS_KEY = 128'h09cf4f3c_abf71588_28aed2a6_2b7e1516;
    localparam logic [127:0] FIPS_K10 = 128'hb6630ca6_e13f0cc8_c9ee2589_d014f9a8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start = 1'b0;
    logic         abort = 1'b0;
    logic [127:0] key_in = '0;
    logic         busy, done, keys_valid;
    logic [3:0]   round_o;
    logic [2:0]   cnt_o;
    logic [127:0] kexp_key_o;
    logic [127:0] round_key_i;
    logic         rk_rd_en = 1'b0;
    logic [3:0]   rk_rd_idx = '0;
    logic [127:0] rk_rd_data;
    logic         rk_rd_valid, rd_err;

    int total = 0;
    int bad   = 0;

    logic [7:0]   sbox_t [256];
    logic [127:0] sched [0:NR];
    logic [127:0] dp_key = '0;
    logic [127:0] dp_noise = '0;

    aes_key_sched_ctrl #(.NR(NR), .CNT_LAST(7)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .key_in(key_in),
        .busy(busy), .done(done), .keys_valid(keys_valid),
        .round_o(round_o), .cnt_o(cnt_o), .kexp_key_o(kexp_key_o),
        .round_key_i(round_key_i),
        .rk_rd_en(rk_rd_en), .rk_rd_idx(rk_rd_idx),
        .rk_rd_data(rk_rd_data), .rk_rd_valid(rk_rd_valid), .rd_err(rd_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return 8'((b << n) | (b >> (8 - n)));
    endfunction

    function automatic logic [7:0] calc_sbox(input logic [7:0] x);
        logic [7:0] inv;
        inv = '0;
        if (x != 8'h00) begin
            for (int y = 1; y < 256; y++) begin
                if (gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
            end
        end
        return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] rcon(input int r);
        logic [7:0] rc;
        rc = 8'h01;
        for (int i = 1; i < r; i++) rc = xtime(rc);
        return rc;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    // Datapath's one-round step: key r-1 -> key r, word w0 in [31:0].
    function automatic logic [127:0] next_key(input logic [127:0] k, input int r);
        logic [31:0] t, n0, n1, n2, n3;
        t  = sub_word(rot_word(k[127:96])) ^ {rcon(r), 24'h0};
        n0 = k[31:0] ^ t;
        n1 = k[63:32] ^ n0;
        n2 = k[95:64] ^ n1;
        n3 = k[127:96] ^ n2;
        return {n3, n2, n1, n0};
    endfunction

    // Reference: FIPS-197 word-by-word expansion into the expected store image.
    task automatic build_sched(input logic [127:0] key);
        logic [31:0] w [0:43];
        logic [31:0] temp;
        for (int i = 0; i < 4; i++) w[i] = key[32*i +: 32];
        for (int i = 4; i < 44; i++) begin
            temp = w[i-1];
            if (i % 4 == 0) temp = sub_word(rot_word(temp)) ^ {rcon(i / 4), 24'h0};
            w[i] = w[i-4] ^ temp;
        end
        for (int r = 0; r <= NR; r++) sched[r] = {w[4*r+3], w[4*r+2], w[4*r+1], w[4*r]};
    endtask

    // External datapath: loads while round=0, steps at the edge ending cnt=7,
    // and only presents a settled key in cnt=0 cycles.
    always @(posedge clk) begin
        if (round_o == 4'd0) dp_key <= kexp_key_o;
        else if (cnt_o == 3'd7) dp_key <= next_key(dp_key, int'(round_o));
        dp_noise <= {$urandom, $urandom, $urandom, $urandom} | 128'h1;
    end
    assign round_key_i = (cnt_o == 3'd0) ? dp_key : (dp_key ^ dp_noise);

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_read(input int idx);
        rk_rd_en  = 1'b1;
        rk_rd_idx = 4'(idx);
        tick();
        rk_rd_en  = 1'b0;
    endtask

    function automatic logic [127:0] rand_key();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Full expansion with a per-cycle round/cnt trace; optional start retry in round 3.
    task automatic run_full(input logic [127:0] key, input bit poke);
        int er, ec;
        build_sched(key);
        key_in = key;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        key_in = rand_key();
        for (int i = 0; i < 82; i++) begin
            er = (i == 0) ? 0 : (i == 81) ? NR : 1 + (i - 1) / 8;
            ec = (i == 0 || i == 81) ? 0 : (i - 1) % 8;
            chk("busy_run", 128'(busy), 128'(1));
            chk("round_trace", 128'(round_o), 128'(er));
            chk("cnt_trace", 128'(cnt_o), 128'(ec));
            chk("done_early", 128'(done), 128'(0));
            chk("kv_cleared", 128'(keys_valid), 128'(0));
            if (poke && er == 3 && ec == 0) begin
                start  = 1'b1;
                key_in = ~key;
            end else begin
                start  = 1'b0;
            end
            tick();
        end
        start = 1'b0;
        chk("busy_end", 128'(busy), 128'(0));
        chk("done_pulse", 128'(done), 128'(1));
        chk("kv_set", 128'(keys_valid), 128'(1));
        chk("round_idle", 128'(round_o), 128'(0));
        chk("cnt_idle", 128'(cnt_o), 128'(0));
        chk("kexp_key", kexp_key_o, key);
    endtask

    task automatic read_all();
        for (int r = 0; r <= NR; r++) begin
            do_read(r);
            chk("rd_valid", 128'(rk_rd_valid), 128'(1));
            chk("rd_err_ok", 128'(rd_err), 128'(0));
            chk($sformatf("rd_key%0d", r), rk_rd_data, sched[r]);
        end
        tick();
        chk("rd_valid_idle", 128'(rk_rd_valid), 128'(0));
        chk("rd_hold", rk_rd_data, sched[NR]);
    endtask

    initial begin
        rst_n = 1'b0;
        for (int i = 0; i < 256; i++) sbox_t[i] = calc_sbox(8'(i));
        #3;
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst_done", 128'(done), 128'(0));
        chk("rst_kv", 128'(keys_valid), 128'(0));
        chk("rst_round", 128'(round_o), 128'(0));
        chk("rst_rdval", 128'(rk_rd_valid), 128'(0));
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // FIPS-197 vector, read served in the done cycle
        run_full(FIPS_KEY, 1'b0);
        rk_rd_en  = 1'b1;
        rk_rd_idx = 4'd0;
        tick();
        rk_rd_en  = 1'b0;
        chk("done_once", 128'(done), 128'(0));
        chk("kv_held", 128'(keys_valid), 128'(1));
        chk("rd0_valid", 128'(rk_rd_valid), 128'(1));
        chk("rd0_key", rk_rd_data, FIPS_KEY);
        do_read(10);
        chk("rd10_fips", rk_rd_data, FIPS_K10);
        read_all();

        // start while busy is ignored
        run_full(FIPS_KEY, 1'b1);
        do_read(10);
        chk("rd10_after_poke", rk_rd_data, FIPS_K10);

        // abort at round 5 / cnt 4
        key_in = rand_key();
        start  = 1'b1;
        tick();
        start  = 1'b0;
        repeat (37) tick();
        chk("abort_at_round", 128'(round_o), 128'(5));
        chk("abort_at_cnt", 128'(cnt_o), 128'(4));
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_busy", 128'(busy), 128'(0));
        chk("abort_round", 128'(round_o), 128'(0));
        chk("abort_cnt", 128'(cnt_o), 128'(0));
        chk("abort_kv", 128'(keys_valid), 128'(0));
        for (int i = 0; i < 3; i++) begin
            chk("abort_no_done", 128'(done), 128'(0));
            tick();
        end
        do_read(2);
        chk("abort_rd_err", 128'(rd_err), 128'(1));
        chk("abort_rd_valid", 128'(rk_rd_valid), 128'(0));
        chk("abort_rd_data", rk_rd_data, 128'(0));
        tick();
        chk("rd_err_pulse", 128'(rd_err), 128'(0));

        // start and abort together in IDLE
        key_in = rand_key();
        start  = 1'b1;
        abort  = 1'b1;
        tick();
        start  = 1'b0;
        abort  = 1'b0;
        chk("sa_busy", 128'(busy), 128'(0));
        chk("sa_round", 128'(round_o), 128'(0));
        tick();
        chk("sa_busy2", 128'(busy), 128'(0));

        // random key, out-of-range reads
        run_full(rand_key(), 1'b0);
        read_all();
        do_read(11);
        chk("rd11_err", 128'(rd_err), 128'(1));
        chk("rd11_data", rk_rd_data, 128'(0));
        do_read(15);
        chk("rd15_err", 128'(rd_err), 128'(1));
        chk("rd15_valid", 128'(rk_rd_valid), 128'(0));
        do_read(10);
        chk("rd10_valid", 128'(rk_rd_valid), 128'(1));
        chk("rd10_rand", rk_rd_data, sched[10]);

        // abort alone in IDLE drops keys_valid
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("idle_abort_kv", 128'(keys_valid), 128'(0));

        // asynchronous reset in round 7
        key_in = rand_key();
        start  = 1'b1;
        tick();
        start  = 1'b0;
        repeat (49) tick();
        chk("rst_at_round", 128'(round_o), 128'(7));
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", 128'(busy), 128'(0));
        chk("arst_round", 128'(round_o), 128'(0));
        chk("arst_cnt", 128'(cnt_o), 128'(0));
        chk("arst_kexp", kexp_key_o, 128'(0));
        chk("arst_rd_data", rk_rd_data, 128'(0));
        chk("arst_done", 128'(done), 128'(0));
        chk("arst_rd_err", 128'(rd_err), 128'(0));
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        run_full(rand_key(), 1'b0);
        read_all();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
